// File: rtl/freq_divider_m_pkg.sv
// freq_divider_m_pkg: shared helpers for the clock divider.
package freq_divider_m_pkg;
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/freq_divider_m.sv
// freq_divider_m: divide clk by M into a registered square wave plus a terminal-count tick.
module freq_divider_m
  import freq_divider_m_pkg::*;
#(
  parameter int M = 12_000_000,
  parameter int W = clog2_min1(M)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  output logic clk_salida,
  output logic tick
);
  localparam logic [W-1:0] CNT_MAX = W'(M - 1);
  localparam logic [W-1:0] HALF    = W'(M / 2);
  logic [W-1:0] r_cnt;
  logic         r_clk_salida;
  logic [W-1:0] w_cnt_nxt;
  if (M < 2) begin : g_bad_m
    $error("freq_divider_m: M must be at least 2");
  end
  // explicit wrap at M-1 so power-of-two M never relies on overflow
  assign w_cnt_nxt = ~ena ? r_cnt : (r_cnt == CNT_MAX) ? '0 : r_cnt + W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_clk_salida <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_clk_salida <= (w_cnt_nxt >= HALF);
    end
  end
  assign clk_salida = r_clk_salida;
  assign tick       = ena & (r_cnt == CNT_MAX);
endmodule

// File: tb/tb_freq_divider_m.sv
// tb_freq_divider_m: directed scoreboard bench for M=5, M=4 and M=2 dividers.
module tb_freq_divider_m;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst5_n, ena5, rst_n, ena;
  logic c5, t5, c4, t4, c2, t2;
  freq_divider_m #(.M(5)) u_m5 (.clk(clk), .rst_n(rst5_n), .ena(ena5), .clk_salida(c5), .tick(t5));
  freq_divider_m #(.M(4)) u_m4 (.clk(clk), .rst_n(rst_n), .ena(ena), .clk_salida(c4), .tick(t4));
  freq_divider_m #(.M(2)) u_m2 (.clk(clk), .rst_n(rst_n), .ena(ena), .clk_salida(c2), .tick(t2));
  typedef struct {
    logic c5, t5, c4, t4, c2, t2;
  } exp_t;
  exp_t sb[$];
  int p5, p4, p2;
  int compared = 0;
  int mismatched = 0;
  int rises5, ticks5;
  logic prev5 = 1'b0;
  logic [4:0] pat5 = 5'b11100;
  logic [3:0] pat4 = 4'b1100;
  logic [1:0] pat2 = 2'b10;
  function automatic int adv(input int p, input int m, input logic r, input logic e);
    return !r ? 0 : !e ? p : (p == m - 1) ? 0 : p + 1;
  endfunction
  task automatic check(input string tag, input logic o, input logic e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic check_int(input string tag, input int o, input int e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic step();
    exp_t x;
    @(posedge clk);
    p5 = adv(p5, 5, rst5_n, ena5);
    p4 = adv(p4, 4, rst_n, ena);
    p2 = adv(p2, 2, rst_n, ena);
    x.c5 = pat5[p5];
    x.t5 = ena5 && (p5 == 4);
    x.c4 = pat4[p4];
    x.t4 = ena && (p4 == 3);
    x.c2 = pat2[p2];
    x.t2 = ena && (p2 == 1);
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    check("m5_clk", c5, x.c5);
    check("m5_tick", t5, x.t5);
    check("m4_clk", c4, x.c4);
    check("m4_tick", t4, x.t4);
    check("m2_clk", c2, x.c2);
    check("m2_tick", t2, x.t2);
    if (c5 && !prev5) rises5++;
    prev5 = c5;
    if (t5) ticks5++;
  endtask
  initial begin
    p5 = 0; p4 = 0; p2 = 0;
    rst5_n = 1'b0; rst_n = 1'b0; ena5 = 1'b1; ena = 1'b1;
    repeat (3) step();
    rst5_n = 1'b1; rst_n = 1'b1;
    rises5 = 0; ticks5 = 0;
    repeat (1500) step();
    check_int("m5_rises", rises5, 300);
    check_int("m5_ticks", ticks5, 300);
    repeat (3) step();
    check_int("m5_phase_before_hold", p5, 3);
    ena5 = 1'b0;
    repeat (7) step();
    ena5 = 1'b1;
    repeat (7) step();
    repeat (3) step();
    rst5_n = 1'b0;
    step();
    check("m5_clk_after_pulse", c5, 1'b0);
    rst5_n = 1'b1;
    repeat (10) step();
    ena = 1'b0;
    repeat (4) step();
    ena = 1'b1;
    repeat (6) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/freq_divider_m.md
Name: freq_divider_m

Overview:
- Parameterised integer clock divider. Produces a square-wave output whose period is exactly M input clock cycles.
- Also produces a one-cycle terminal-count strobe.
- Used in the music-box design to derive low-rate timing and tone clocks from the board clock.
- Fully synchronous: the output is a registered signal used as a clock/enable downstream, never a gated clock.

Parameters:
- M, default 12_000_000, division ratio (output period in input cycles); legal range 2 .. 2^31-1.
- W, default $clog2(M), counter width (derived; not overridden by users).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  count enable; when low, the counter and outputs hold.
- clk_salida  output  1  divided clock, period M cycles, registered.
- tick  output  1  high for one cycle when the counter is at its terminal value M-1 and ena=1.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset (rst_n=0 at a rising edge):
  - cnt <= 0, clk_salida <= 0.
  - tick is 0 during reset.
  - Reset mid-period aborts the period; counting restarts from 0 after release.
- Counter cnt, W bits, range 0..M-1:
  - If ena=1: cnt <= (cnt == M-1) ? 0 : cnt+1.
  - If ena=0: cnt holds.
  - No value outside 0..M-1 is ever reached.
- Output rule, registered:
  - clk_salida is updated together with cnt so that clk_salida == (cnt >= M/2) holds at every cycle. M/2 uses integer floor.
  - Low for floor(M/2) cycles, then high for ceil(M/2) cycles.
  - Even M gives exactly 50% duty. Odd M has the high phase one cycle longer; e.g. M=5 gives 2 low, 3 high.
- Period:
  - With ena held high, clk_salida rises once every M cycles.
  - First rising edge occurs floor(M/2) enabled cycles after reset release.
- tick:
  - Combinational from registered state: tick = ena & (cnt == M-1).
  - Exactly one cycle high per M enabled cycles, coincident with the last high cycle of clk_salida.
- ena deasserted:
  - Everything freezes, including the clk_salida level.
  - tick is forced low.
  - Resuming continues from the frozen count; no phase loss.
- Simultaneous events: rst_n=0 has priority over ena.
- Parameter check: M < 2 is illegal and must raise an elaboration-time error (generate-time $error or equivalent).
- Widths:
  - Comparisons use W-bit constants M-1 and M/2.
  - W = max(1, $clog2(M)).
  - M a power of two must still wrap at M-1 (no reliance on natural overflow).
- No combinational path from inputs to clk_salida. tick depends on ena combinationally.

Decomposition:
- No shared package required.
- Local constants CNT_MAX = M-1 and HALF = M/2 live in the module.
- Single module, no sub-modules.
- Optional: a shared helper function clog2_min1 in the project's common utilities package if one already exists.

Test Plan:
- M=5, ena=1, rst_n low 3 cycles then high, run 1500 cycles:
  - clk_salida pattern 0,0,1,1,1 repeating from reset release.
  - Exactly 300 rising edges.
  - tick high on every 5th cycle, at cnt=4.
- M=4: clk_salida 0,0,1,1 repeating (50% duty); tick period 4; counter wraps 3->0.
- M=5, ena dropped for 7 cycles at cnt=3:
  - clk_salida stays 1 and tick stays 0 during the hold.
  - After re-enable, sequence continues 4,0,... with no phase loss.
- M=5, rst_n pulsed low one cycle at cnt=3: next cycle cnt=0 and clk_salida=0; pattern restarts 0,0,1,1,1.
- M=2: clk_salida toggles every cycle (0,1,0,1); tick high whenever clk_salida=1.
- M=1 instance: elaboration fails with a parameter error.
